// File: rtl/simd_register_file.sv
// simd_register_file
// Dual-read, single-write register file for the decode stage.
//   * scalar bank: SREGS x N bits. Index 0 reads as zero, index 1 is sp
//     (reset to SP_INIT), index SREGS-1 is pc and is loaded from r15 every cycle.
//   * vector bank: VREGS x (LANES*N) bits, with lane-masked writes.
//   * registered reads: an address presented in cycle t appears on rd1/rd2 in cycle t+1.
//   * clear sequencer: zeroes one vector register per cycle.
// Optional build macro: RF_BYPASS_EN. When it is defined, a read of the register
// being written in the same cycle returns the post-write value. When it is left
// undefined, the read returns the pre-write value.
//
// Clear handshake: a pulse on clr_req is accepted only while clr_busy is low.
// clr_busy stays high from the cycle after acceptance until the end of the
// clr_done cycle. clr_done is a one-cycle pulse. Requests made while busy are ignored.
module simd_register_file #(
    parameter int N = 32,
    parameter int LANES = 4,
    parameter int SREGS = 16,
    parameter int VREGS = 8,
    parameter logic [N-1:0] SP_INIT = 32'h000DE000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ra1,
    input  logic [4:0]           ra2,
    input  logic [4:0]           wa3,
    input  logic [LANES*N-1:0]   wd3,
    input  logic                 we3,
    input  logic [LANES-1:0]     wmask,
    input  logic [N-1:0]         r15,
    input  logic                 clr_req,
    output logic                 clr_busy,
    output logic                 clr_done,
    output logic [LANES*N-1:0]   rd1,
    output logic [LANES*N-1:0]   rd2,
    output logic [1:0]           dbg_clr_state
);

    localparam int W      = LANES * N;
    localparam int SW     = (SREGS > 1) ? $clog2(SREGS) : 1;
    localparam int VW     = (VREGS > 1) ? $clog2(VREGS) : 1;
    localparam int PC_IDX = SREGS - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    logic [N-1:0]  sregs [SREGS];
    logic [W-1:0]  vregs [VREGS];

    clr_state_t    state_q, state_d;
    logic [VW-1:0] cnt_q, cnt_d;

    logic [3:0]    w_idx;
    logic [SW-1:0] s_widx;
    logic [VW-1:0] v_widx;
    logic          s_we;
    logic          v_we;
    logic [W-1:0]  v_merged;

    logic [4:0]    ra_sel [2];
    logic [W-1:0]  rdata  [2];

    assign w_idx  = wa3[3:0];
    assign s_widx = w_idx[SW-1:0];
    assign v_widx = w_idx[VW-1:0];

    assign clr_busy      = (state_q != ST_IDLE);
    assign clr_done      = (state_q == ST_DONE);
    assign dbg_clr_state = state_q;

    // Scalar writes skip the zero register, the pc register and indexes outside the bank.
    assign s_we = we3 && !wa3[4] && (w_idx != 4'd0)
                  && ({1'b0, w_idx} < 5'(SREGS))
                  && ({1'b0, w_idx} != 5'(PC_IDX));

    // While a clear is running, vector writes are dropped as a whole.
    assign v_we = we3 && wa3[4] && ({1'b0, w_idx} < 5'(VREGS)) && !clr_busy;

    assign ra_sel[0] = ra1;
    assign ra_sel[1] = ra2;

    // Post-write image of the addressed vector register. Unmasked lanes keep their old data.
    always_comb begin
        v_merged = vregs[v_widx];
        for (int l = 0; l < LANES; l++) begin
            if (wmask[l]) begin
                v_merged[l*N +: N] = wd3[l*N +: N];
            end
        end
    end

    // Read-port decode: zero register, out-of-range all-ones, optional write bypass.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            if (!ra_sel[p][4]) begin
                if ({1'b0, ra_sel[p][3:0]} >= 5'(SREGS)) begin
                    rdata[p] = '1;
                end else if (ra_sel[p][3:0] != 4'd0) begin
                    rdata[p][N-1:0] = sregs[ra_sel[p][SW-1:0]];
`ifdef RF_BYPASS_EN
                    if (s_we && (ra_sel[p][3:0] == w_idx)) begin
                        rdata[p][N-1:0] = wd3[N-1:0];
                    end
`endif
                end
            end else begin
                if ({1'b0, ra_sel[p][3:0]} >= 5'(VREGS)) begin
                    rdata[p] = '1;
                end else begin
                    rdata[p] = vregs[ra_sel[p][VW-1:0]];
`ifdef RF_BYPASS_EN
                    if (v_we && (ra_sel[p][3:0] == w_idx)) begin
                        rdata[p] = v_merged;
                    end
`endif
                end
            end
        end
    end

    // Registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd1 <= '0;
            rd2 <= '0;
        end else begin
            rd1 <= rdata[0];
            rd2 <= rdata[1];
        end
    end

    // Scalar bank: accepted writes, then pc is reloaded from r15 (the r15 load wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SREGS; i++) begin
                sregs[i] <= '0;
            end
            sregs[1] <= SP_INIT;
        end else begin
            if (s_we) begin
                sregs[s_widx] <= wd3[N-1:0];
            end
            sregs[PC_IDX] <= r15;
        end
    end

    // Vector bank: masked writes, or one register zeroed per cycle while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < VREGS; i++) begin
                vregs[i] <= '0;
            end
        end else begin
            if (v_we) begin
                vregs[v_widx] <= v_merged;
            end
            if (state_q == ST_CLEAR) begin
                vregs[cnt_q] <= '0;
            end
        end
    end

    // Clear sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Clear sequencer next state: IDLE -> CLEAR (VREGS cycles) -> DONE (1 cycle) -> IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == VW'(VREGS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule
